// File: rtl/bp_be_prefetch_scheduler.sv
// Prefetch scheduler: buffers stride-detector streams in a FIFO and walks each one into the D$ prefetch port.
// Optional statistics counters are enabled by defining BP_BE_PREFETCH_STATS_EN.
module bp_be_prefetch_scheduler #(
  parameter int vaddr_width_p  = 39,
  parameter int stride_width_p = 8,
  parameter int queue_els_p    = 4,
  parameter int degree_p       = 4,
  parameter int stat_width_p   = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]  striding_pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_and_i,
  output logic                      busy_o,
  output logic [stat_width_p-1:0]   issue_count_o,
  output logic [stat_width_p-1:0]   drop_count_o
);

  localparam int PTR_W = $clog2(queue_els_p);
  localparam int PW    = PTR_W + 1;
  localparam logic [3:0] DEG_CONF = 4'(degree_p);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  function automatic logic signed [vaddr_width_p-1:0] sext_stride(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  // Stage p0: stream FIFO
  logic [vaddr_width_p-1:0]  pc_mem     [queue_els_p];
  logic [vaddr_width_p-1:0]  addr_mem   [queue_els_p];
  logic [stride_width_p-1:0] stride_mem [queue_els_p];
  logic [3:0]                deg_mem    [queue_els_p];
  logic [PW-1:0]             wptr_p0, rptr_p0;

  logic [0:0]                state_p1;
  logic [vaddr_width_p-1:0]  cur_addr_p1;
  logic [vaddr_width_p-1:0]  cur_pc_p1;
  logic [stride_width_p-1:0] cur_stride_p1;
  logic [3:0]                rem_p1;

  logic empty, full, issuing, hs, last, pop, in_v, drop_in, enq;
  logic [PTR_W-1:0] head;
  logic signed [vaddr_width_p-1:0] head_step, cur_step;

  assign empty   = (wptr_p0 == rptr_p0);
  assign full    = (wptr_p0[PTR_W] != rptr_p0[PTR_W]) &&
                   (wptr_p0[PTR_W-1:0] == rptr_p0[PTR_W-1:0]);
  assign head    = rptr_p0[PTR_W-1:0];
  assign issuing = (state_p1 == ISSUE);
  assign hs      = issuing & pf_ready_and_i;
  assign last    = hs & (rem_p1 == 4'd1);
  // Refill straight from the FIFO on the final handshake so streams run back-to-back.
  assign pop     = ~flush_i & ~empty & (~issuing | last);

  assign in_v    = start_discovery_i | confirm_discovery_i;
  assign drop_in = (stride_i == '0) | (full & ~pop) | flush_i |
                   (issuing & (cur_pc_p1 == striding_pc_i));
  assign enq     = in_v & ~drop_in;

  assign head_step = sext_stride(stride_mem[head]);
  assign cur_step  = sext_stride(cur_stride_p1);

  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wptr_p0[PTR_W-1:0]]     <= striding_pc_i;
      addr_mem[wptr_p0[PTR_W-1:0]]   <= eff_addr_i;
      stride_mem[wptr_p0[PTR_W-1:0]] <= stride_i;
      deg_mem[wptr_p0[PTR_W-1:0]]    <= confirm_discovery_i ? DEG_CONF : 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else if (flush_i) begin
      rptr_p0 <= wptr_p0;
    end else begin
      if (enq) wptr_p0 <= wptr_p0 + PW'(1);
      if (pop) rptr_p0 <= rptr_p0 + PW'(1);
    end
  end

  // Stage p1: issue engine
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_p1    <= IDLE;
      cur_addr_p1 <= '0;
      rem_p1      <= '0;
    end else if (flush_i) begin
      state_p1 <= IDLE;
    end else if (pop) begin
      state_p1    <= ISSUE;
      cur_addr_p1 <= addr_mem[head] + $unsigned(head_step);
      rem_p1      <= deg_mem[head];
    end else if (hs) begin
      if (last) begin
        state_p1 <= IDLE;
      end else begin
        cur_addr_p1 <= cur_addr_p1 + $unsigned(cur_step);
        rem_p1      <= rem_p1 - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      cur_pc_p1     <= pc_mem[head];
      cur_stride_p1 <= stride_mem[head];
    end
  end

  assign pf_v_o    = issuing;
  assign pf_addr_o = cur_addr_p1;
  assign busy_o    = issuing | ~empty;

`ifdef BP_BE_PREFETCH_STATS_EN
  function automatic logic [stat_width_p-1:0] sat_inc(input logic [stat_width_p-1:0] c);
    return (&c) ? c : c + stat_width_p'(1);
  endfunction

  logic [stat_width_p-1:0] issue_cnt, drop_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issue_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (hs)              issue_cnt <= sat_inc(issue_cnt);
      if (in_v & ~enq)     drop_cnt  <= sat_inc(drop_cnt);
    end
  end

  assign issue_count_o = issue_cnt;
  assign drop_count_o  = drop_cnt;
`else
  assign issue_count_o = '0;
  assign drop_count_o  = '0;
`endif

endmodule
